// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and word geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int LOADER_WORD_BYTES = 4;

  // States in which the loader is mid-frame and takes bytes from the source.
  function automatic logic loader_accepts(loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader, bundled for port connection.
// Latency: n/a (wiring only).
// Backpressure: rx side is valid/ready; the imem write side has none.
// Signals: rx_valid/rx_data/rx_ready (byte stream), imem_wr_en/imem_wr_addr/imem_wr_data (write port).
// master = byte source and memory side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_wr_en;
  logic [ADDR_WIDTH-1:0] imem_wr_addr;
  logic [31:0]           imem_wr_data;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );
endinterface

// File: rtl/imem_loader_word_pack.sv
// Packs accepted payload bytes into little-endian 32-bit words.
// Latency: word/word_full are combinational on the 4th byte (word includes that byte).
// Backpressure: none; accepts a byte whenever byte_vld is high.
// Ports: clk, res (sync), clr (restart packing), byte_vld/byte_dat in; word, word_full out.
module imem_loader_word_pack
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  idx;
  logic [31:0] acc;

  // Current byte inserted at its lane so the full word is available in the
  // same cycle as the last byte; that keeps the write to one cycle after it.
  always_comb begin
    word = acc;
    word[{idx, 3'b000} +: 8] = byte_dat;
  end

  assign word_full = byte_vld && (idx == 2'(LOADER_WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (res || clr) begin
      idx <= 2'd0;
      acc <= 32'd0;
    end else if (byte_vld) begin
      acc <= word;
      idx <= idx + 2'd1;  // wraps to lane 0 after the 4th byte
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image (LEN_LO, LEN_HI, 4*N payload bytes, XOR CHK) into imem and releases the core.
// Latency: imem write exactly 1 cycle after the 4th byte of each word; done/err 1 cycle after CHK.
// Backpressure: rx_ready high only while mid-frame; the write port is never stalled.
// Ports: clk, res (sync, active high), start; bus (byte stream in, imem write out); core_res_n, done, err.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            res,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            core_res_n,
  output logic            done,
  output logic            err
);

  localparam int CAP_WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);

  loader_state_t state;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   word_idx;
  logic [7:0]    checksum;
  logic [TW-1:0] idle_cnt;

  logic        active;
  logic        hs;
  logic        begin_load;
  logic [15:0] len_n;
  logic [31:0] word;
  logic        word_full;

  assign active     = loader_accepts(state);
  assign bus.rx_ready = active;
  assign hs         = bus.rx_valid && active;
  // start is only honoured outside a frame, so a timeout always wins over it.
  assign begin_load = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign len_n      = {bus.rx_data, len_lo};

  imem_loader_word_pack u_pack (
    .clk       (clk),
    .res       (res),
    .clr       (begin_load),
    .byte_vld  (hs && (state == DATA)),
    .byte_dat  (bus.rx_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state            <= IDLE;
      len_lo           <= 8'd0;
      len              <= 16'd0;
      word_idx         <= 16'd0;
      checksum         <= 8'd0;
      idle_cnt         <= '0;
      bus.imem_wr_en   <= 1'b0;
      bus.imem_wr_addr <= '0;
      bus.imem_wr_data <= 32'd0;
      core_res_n       <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      bus.imem_wr_en <= 1'b0;
      if (begin_load) begin
        state      <= LEN_LO;
        done       <= 1'b0;
        err        <= 1'b0;
        core_res_n <= 1'b0;
        checksum   <= 8'd0;
        word_idx   <= 16'd0;
        idle_cnt   <= '0;
      end else if (active) begin
        if (!hs) begin
          if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state    <= ERROR;
            err      <= 1'b1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end else begin
          idle_cnt <= '0;
          case (state)
            LEN_LO: begin
              len_lo <= bus.rx_data;
              state  <= LEN_HI;
            end
            LEN_HI: begin
              len <= len_n;
              if (32'(len_n) > CAP_WORDS) begin
                state <= ERROR;
                err   <= 1'b1;
              end else if (len_n == 16'd0) begin
                state <= CHECK;
              end else begin
                state <= DATA;
              end
            end
            DATA: begin
              checksum <= checksum ^ bus.rx_data;
              if (word_full) begin
                bus.imem_wr_en   <= 1'b1;
                bus.imem_wr_addr <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
                bus.imem_wr_data <= word;
                word_idx         <= word_idx + 16'd1;
                if (word_idx + 16'd1 == len) state <= CHECK;
              end
            end
            CHECK: begin
              if (bus.rx_data == checksum) begin
                state      <= DONE;
                done       <= 1'b1;
                core_res_n <= 1'b1;
              end else begin
                state <= ERROR;
                err   <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames driven byte by byte, expected writes derived from the payload.
// Latency: expects each write one cycle after the 4th byte handshake of its word.
// Backpressure: driver holds rx_valid until it sees rx_ready.
module tb_imem_loader;

  logic clk = 1'b0;
  logic res;
  logic start;
  logic core_res_n;
  logic done;
  logic err;

  imem_loader_if #(.ADDR_WIDTH(8)) bus ();

  imem_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYC(1024)) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .bus        (bus),
    .core_res_n (core_res_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  int          wr_count = 0;
  wr_t         exp_q[$];
  wr_t         e;
  logic [7:0]  pl[$];
  logic [7:0]  last_xor;
  logic [31:0] seen[0:63];
  int          wr_before;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-cycle compare: every write must match the next expected write, on the expected cycle.
  always @(negedge clk) begin
    ncyc++;
    chk("done_err_exclusive", 32'(done & err), 32'd0);
    chk("core_res_n_eq_done", 32'(core_res_n), 32'(done));
    if (bus.imem_wr_en === 1'b1) begin
      wr_count++;
      seen[bus.imem_wr_addr[7:2]] = bus.imem_wr_data;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imem_wr_addr), 32'(e.addr));
        chk("wr_data", bus.imem_wr_data, e.data);
        chk("wr_cycle", 32'(ncyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic st, input bit ew,
                           input logic [7:0] ea, input logic [31:0] ed);
    bit got = 1'b0;
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    start        = st;
    while (!got && n < 200) begin
      if (bus.rx_ready === 1'b1) begin
        if (ew) exp_q.push_back('{ncyc + 1, ea, ed});
        got = 1'b1;
      end
      tick(1);
      n++;
    end
    bus.rx_valid = 1'b0;
    start        = 1'b0;
    if (!got) chk("rx_ready_timeout", 32'd0, 32'd1);
  endtask

  // Sends LEN, payload from pl, then CHK = XOR(payload) ^ chk_flip.
  // stop_after >= 0 sends only that many payload bytes and stops.
  task automatic send_frame(input logic [15:0] n, input logic [7:0] chk_flip,
                            input int start_at, input int stop_after);
    logic [7:0] x = 8'd0;
    int np;
    send_byte(n[7:0], 1'b0, 1'b0, 8'd0, 32'd0);
    send_byte(n[15:8], 1'b0, 1'b0, 8'd0, 32'd0);
    if (n > 16'd64) return;
    np = (stop_after < 0) ? pl.size() : stop_after;
    for (int i = 0; i < np; i++) begin
      x ^= pl[i];
      if (i % 4 == 3)
        send_byte(pl[i], i == start_at, 1'b1, 8'(4 * (i / 4)),
                  {pl[i], pl[i-1], pl[i-2], pl[i-3]});
      else
        send_byte(pl[i], i == start_at, 1'b0, 8'd0, 32'd0);
    end
    if (stop_after >= 0) return;
    last_xor = x;
    send_byte(x ^ chk_flip, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  initial begin
    res          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    res = 1'b0;
    tick(10);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_core_res_n", 32'(core_res_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_data", bus.imem_wr_data, 32'd0);

    // Two-word program with the correct checksum (XOR of payload is 0xB0).
    pl = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    pulse_start();
    send_frame(16'd2, 8'h00, -1, -1);
    tick(3);
    chk("a_model_xor", 32'(last_xor), 32'h0000_00B0);
    chk("a_word0_lit", seen[0], 32'h0010_0513);
    chk("a_word1_lit", seen[1], 32'h0020_0593);
    chk("a_done", 32'(done), 32'd1);
    chk("a_err", 32'(err), 32'd0);
    chk("a_core_res_n", 32'(core_res_n), 32'd1);
    chk("a_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("a_pending", 32'(exp_q.size()), 32'd0);

    // Same frame, CHK = 0x81: writes still happen, then error.
    pulse_start();
    send_frame(16'd2, 8'h31, -1, -1);
    tick(3);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_core_res_n", 32'(core_res_n), 32'd0);
    chk("bad_pending", 32'(exp_q.size()), 32'd0);

    // 65 words exceeds the 64-word capacity.
    wr_before = wr_count;
    pulse_start();
    send_frame(16'h0041, 8'h00, -1, -1);
    chk("big_err", 32'(err), 32'd1);
    chk("big_rx_ready", 32'(bus.rx_ready), 32'd0);
    tick(3);
    chk("big_writes", 32'(wr_count - wr_before), 32'd0);

    // Empty image, CHK = 0.
    pl.delete();
    pulse_start();
    send_frame(16'd0, 8'h00, -1, -1);
    tick(2);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_err", 32'(err), 32'd0);

    // Stall after 2 payload bytes.
    pl = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    wr_before = wr_count;
    pulse_start();
    send_frame(16'd2, 8'h00, -1, 2);
    tick(1018);
    chk("to_no_err_early", 32'(err), 32'd0);
    tick(10);
    chk("to_err", 32'(err), 32'd1);
    chk("to_done", 32'(done), 32'd0);
    chk("to_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("to_writes", 32'(wr_count - wr_before), 32'd0);

    // Recovery: three words, start pulsed mid-payload must be ignored.
    pl = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
           8'h01, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame(16'd3, 8'h00, 5, -1);
    tick(3);
    chk("rec_done", 32'(done), 32'd1);
    chk("rec_err", 32'(err), 32'd0);
    chk("rec_word0_lit", seen[0], 32'h1234_5678);
    chk("rec_word1_lit", seen[1], 32'hDEAD_BEEF);
    chk("rec_word2_lit", seen[2], 32'h0000_0001);
    chk("rec_pending", 32'(exp_q.size()), 32'd0);

    // Reset after 6 payload bytes: one word written, nothing after.
    pl = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    wr_before = wr_count;
    pulse_start();
    send_frame(16'd2, 8'h00, -1, 6);
    res = 1'b1;
    tick(1);
    res = 1'b0;
    tick(10);
    chk("abort_writes", 32'(wr_count - wr_before), 32'd1);
    chk("abort_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_core_res_n", 32'(core_res_n), 32'd0);
    chk("abort_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
